// File: rtl/tetris_pkg.sv
// Shared board geometry, row type, line-clear FSM states and score table.
package tetris_pkg;

   localparam int unsigned BOARD_W     = 10;
   localparam int unsigned BOARD_H     = 20;
   localparam int unsigned ROW_AW      = $clog2(BOARD_H);
   localparam int unsigned PTR_W       = ROW_AW + 1;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned DEF_SCORE_W = 16;

   // Points per pass by number of rows removed
   localparam int unsigned PTS_W   = 11;
   localparam int unsigned SCORE_1 = 40;
   localparam int unsigned SCORE_2 = 100;
   localparam int unsigned SCORE_3 = 300;
   localparam int unsigned SCORE_4 = 1200;

   typedef logic [BOARD_W-1:0] row_t;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RDW,
      FILL,
      DONE
   } lc_state_t;

   function automatic logic [PTS_W-1:0] score_pts(input logic [CNT_W-1:0] n);
      logic [PTS_W-1:0] pts;
      case (n)
         3'd0:    pts = '0;
         3'd1:    pts = PTS_W'(SCORE_1);
         3'd2:    pts = PTS_W'(SCORE_2);
         3'd3:    pts = PTS_W'(SCORE_3);
         default: pts = PTS_W'(SCORE_4);
      endcase
      return pts;
   endfunction

endpackage

// File: rtl/line_clear_ctrl.sv
// Post-lock board sequencer: scans rows bottom-up, drops full rows, compacts the
// rest downward, zero-fills the top and reports lines cleared plus saturating score.
module line_clear_ctrl
   import tetris_pkg::*;
#(
   parameter int unsigned SCORE_W = DEF_SCORE_W
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     lines_cleared,
   output logic [SCORE_W-1:0]   score,
   output logic                 rd_en,
   output logic [ROW_AW-1:0]    rd_addr,
   input  row_t                 rd_data,
   output logic                 wr_en,
   output logic [ROW_AW-1:0]    wr_addr,
   output row_t                 wr_data
);

   lc_state_t            state, state_nxt;
   logic [PTR_W-1:0]     r, r_nxt;
   logic [PTR_W-1:0]     w, w_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_upd;
   logic                 busy_nxt, done_nxt, rd_en_nxt, wr_en_nxt;
   logic [CNT_W-1:0]     lines_nxt;
   logic [SCORE_W-1:0]   score_nxt;
   logic [ROW_AW-1:0]    rd_addr_nxt, wr_addr_nxt;
   row_t                 wr_data_nxt;
   logic                 row_full;

   // Single add with a carry-out compare; the score never wraps
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                  input logic [CNT_W-1:0]   n);
      logic [SCORE_W:0] sum;
      sum = {1'b0, s} + (SCORE_W+1)'(score_pts(n));
      return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   endfunction

   assign row_full = &rd_data;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state         <= IDLE;
         r             <= '0;
         w             <= '0;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         lines_cleared <= '0;
         score         <= '0;
         rd_en         <= 1'b0;
         rd_addr       <= '0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
      end else begin
         state         <= state_nxt;
         r             <= r_nxt;
         w             <= w_nxt;
         cnt           <= cnt_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         lines_cleared <= lines_nxt;
         score         <= score_nxt;
         rd_en         <= rd_en_nxt;
         rd_addr       <= rd_addr_nxt;
         wr_en         <= wr_en_nxt;
         wr_addr       <= wr_addr_nxt;
         wr_data       <= wr_data_nxt;
      end
   end

   // RAM strobes are issued one state early so they are registered yet land in RD/FILL timing
   always_comb begin
      state_nxt   = state;
      r_nxt       = r;
      w_nxt       = w;
      cnt_nxt     = cnt;
      cnt_upd     = cnt;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      lines_nxt   = lines_cleared;
      score_nxt   = score;
      rd_en_nxt   = 1'b0;
      rd_addr_nxt = rd_addr;
      wr_en_nxt   = 1'b0;
      wr_addr_nxt = wr_addr;
      wr_data_nxt = wr_data;

      case (state)
         IDLE: begin
            if (start) begin
               r_nxt       = PTR_W'(BOARD_H - 1);
               w_nxt       = PTR_W'(BOARD_H - 1);
               cnt_nxt     = '0;
               busy_nxt    = 1'b1;
               rd_en_nxt   = 1'b1;
               rd_addr_nxt = ROW_AW'(BOARD_H - 1);
               state_nxt   = RD;
            end
         end

         RD: state_nxt = RDW;

         RDW: begin
            if (row_full) begin
               cnt_upd = (cnt == '1) ? cnt : cnt + CNT_W'(1);
            end else begin
               if (w != r) begin
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = ROW_AW'(w);
                  wr_data_nxt = rd_data;
               end
               w_nxt = w - PTR_W'(1);
            end
            cnt_nxt = cnt_upd;

            if (r == '0) begin
               if (cnt_upd != '0) begin
                  state_nxt = FILL;
               end else begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  lines_nxt = cnt_upd;
                  score_nxt = sat_add(score, cnt_upd);
               end
            end else begin
               r_nxt       = r - PTR_W'(1);
               rd_en_nxt   = 1'b1;
               rd_addr_nxt = ROW_AW'(r - PTR_W'(1));
               state_nxt   = RD;
            end
         end

         FILL: begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = ROW_AW'(w);
            wr_data_nxt = '0;
            w_nxt       = w - PTR_W'(1);
            if (w == '0) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               lines_nxt = cnt;
               score_nxt = sat_add(score, cnt);
            end
         end

         DONE: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
